// File: rtl/systolic_fpga_example_axis_gen_pkg.sv
// Shared types and constants for the systolic example AXI4-Stream generator:
// FSM encoding, lane-count derivation and the all-ones tkeep constant.
`default_nettype none

package systolic_fpga_example_axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest supported tkeep (1024-bit tdata); the top slices what it needs.
  localparam int                      KEEP_MAX_W    = 128;
  localparam logic [KEEP_MAX_W-1:0]   KEEP_ALL_ONES = '1;

  function automatic int lanes_of(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_fpga_example_axis_gen_if.sv
// AXI4-Stream bundle between the generator (master) and its sink (slave).
`default_nettype none

interface systolic_fpga_example_axis_gen_if #(
  parameter int DW = 512
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/systolic_fpga_example_axis_gen_lane.sv
// One pattern lane: loads seed+INDEX on start, then steps by LANES per handshake.
`default_nettype none

module systolic_fpga_example_axis_gen_lane #(
  parameter int W     = 32,
  parameter int LANES = 16,
  parameter int INDEX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] lane_o
);

  logic [W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (load_i) begin
      lane_q <= seed_i + W'(INDEX);
    end else if (adv_i) begin
      lane_q <= lane_q + W'(LANES);
    end
  end

  assign lane_o = lane_q;

endmodule

`default_nettype wire

// File: rtl/systolic_fpga_example_axis_gen.sv
// AXI4-Stream traffic generator emitting ctrl_length lane-incrementing beats.
// Optional stall counter: define SYSTOLIC_AXIS_GEN_STALL_CNT_EN.
`default_nettype none

module systolic_fpga_example_axis_gen
  import systolic_fpga_example_axis_gen_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_LENGTH_WIDTH     = 32
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_aresetn,
  input  logic                         ctrl_start,
  input  logic [C_LENGTH_WIDTH-1:0]    ctrl_length,
  input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_seed,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic [31:0]                  stat_stall_cycles,
  systolic_fpga_example_axis_gen_if.master m_axis
);

  localparam int LANES = lanes_of(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);
  localparam int KW    = C_AXIS_TDATA_WIDTH / 8;

  state_e                      state_q, state_d;
  logic [C_LENGTH_WIDTH-1:0]   remaining_q, remaining_d;
  logic                        accept;
  logic                        valid;
  logic                        handshake;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_w;

  assign accept    = (state_q == ST_IDLE) && ctrl_start;
  assign valid     = (state_q == ST_RUN);
  assign handshake = valid && m_axis.tready;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          remaining_d = ctrl_length;
          state_d     = (ctrl_length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          remaining_d = remaining_q - C_LENGTH_WIDTH'(1);
          if (remaining_q == C_LENGTH_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      systolic_fpga_example_axis_gen_lane #(
        .W     (C_ADDER_BIT_WIDTH),
        .LANES (LANES),
        .INDEX (gi)
      ) u_lane (
        .clk    (m_axis_aclk),
        .rst_n  (m_axis_aresetn),
        .load_i (accept),
        .adv_i  (handshake),
        .seed_i (ctrl_seed),
        .lane_o (tdata_w[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH])
      );
    end
  endgenerate

  // All payload fields derive from registered state, so they are stable
  // until the handshake and tvalid never sees tready combinationally.
  assign m_axis.tvalid = valid;
  assign m_axis.tdata  = tdata_w;
  assign m_axis.tkeep  = valid ? KEEP_ALL_ONES[KW-1:0] : KW'(0);
  assign m_axis.tlast  = valid && (remaining_q == C_LENGTH_WIDTH'(1));
  assign ctrl_busy     = valid;
  assign ctrl_done     = (state_q == ST_DONE);

`ifdef SYSTOLIC_AXIS_GEN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (valid && !m_axis.tready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_stall_cycles = stall_q;
`else
  assign stat_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire
